// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the M-extension unit.
// master = issuing core, slave = muldiv_seq.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             busy;

  modport master (
    output req_valid, op, src_a, src_b, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  modport slave (
    input  req_valid, op, src_a, src_b, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M mul/div: 32-step shift-add and restoring divide.
// MULDIV_FAST_MUL_EN: multiplies done in one cycle with a `*`.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  localparam int W = WIDTH;
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic   w_load;
  logic   w_fin;

  logic [4:0]     r_count;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_result;
  logic [2*W-1:0] r_acc;
  logic [W:0]     r_rem;

  logic         w_sgn_a;
  logic         w_sgn_b;
  logic         w_neg_a;
  logic         w_neg_b;
  logic         w_div;
  logic         w_dz;
  logic         w_ovf;
  logic         w_neg_res;
  logic         w_short;
  logic [W-1:0] w_mag_a;
  logic [W-1:0] w_mag_b;
  logic [W-1:0] w_spec_res;
  logic [W-1:0] w_short_res;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    unique case (bus.op)
      3'd1, 3'd4, 3'd6: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      3'd2: w_sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & bus.src_a[W-1];
  assign w_neg_b = w_sgn_b & bus.src_b[W-1];
  assign w_mag_a = w_neg_a ? -bus.src_a : bus.src_a;
  assign w_mag_b = w_neg_b ? -bus.src_b : bus.src_b;

  assign w_div = bus.op[2];
  assign w_dz  = w_div && (bus.src_b == '0);
  assign w_ovf = w_div && !bus.op[0] &&
                 (bus.src_a == MIN_NEG) &&
                 (bus.src_b == ALL_ONES);

  // remainder follows the dividend; product/quotient follow sign xor
  assign w_neg_res = (w_div && bus.op[1]) ? w_neg_a
                                          : (w_neg_a ^ w_neg_b);

  assign w_spec_res = w_dz ? (bus.op[1] ? bus.src_a : ALL_ONES)
                           : (bus.op[1] ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fa;
  logic [2*W-1:0] w_fb;
  logic [2*W-1:0] w_fp;
  logic [W-1:0]   w_fast_res;

  assign w_fa = {{W{w_neg_a}}, bus.src_a};
  assign w_fb = {{W{w_neg_b}}, bus.src_b};
  assign w_fp = w_fa * w_fb;
  assign w_fast_res = (bus.op[1:0] == 2'd0) ? w_fp[W-1:0]
                                            : w_fp[2*W-1:W];
  assign w_short     = w_dz | w_ovf | !w_div;
  assign w_short_res = w_div ? w_spec_res : w_fast_res;
`else
  assign w_short     = w_dz | w_ovf;
  assign w_short_res = w_spec_res;
`endif

  logic [W:0]     w_msum;
  logic [2*W-1:0] w_acc_mul;
  logic [2*W-1:0] w_prod;
  logic [W+1:0]   w_shift;
  logic [W+1:0]   w_trial;
  logic [W:0]     w_rem_nx;
  logic [W-1:0]   w_quo_nx;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_final;

  assign w_msum    = {1'b0, r_acc[2*W-1:W]} +
                     {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_acc_mul = {w_msum, r_acc[W-1:1]};
  assign w_prod    = r_neg ? -w_acc_mul : w_acc_mul;

  // low half of r_acc shifts dividend bits out and quotient bits in
  assign w_shift  = {r_rem, r_acc[W-1]};
  assign w_trial  = w_shift - {2'b00, r_b};
  assign w_rem_nx = w_trial[W+1] ? w_shift[W:0] : w_trial[W:0];
  assign w_quo_nx = {r_acc[W-2:0], ~w_trial[W+1]};
  assign w_quo    = r_neg ? -w_quo_nx : w_quo_nx;
  assign w_rem    = r_neg ? -w_rem_nx[W-1:0] : w_rem_nx[W-1:0];

  always_comb begin
    w_final = w_quo;
    if (r_op[2])
      w_final = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'd0)
      w_final = w_prod[W-1:0];
    else
      w_final = w_prod[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_fin      = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_load     = 1'b1;
        w_state_nx = w_short ? S_DONE : S_CALC;
      end
      S_CALC: if (r_count == 5'd31) begin
        w_fin      = 1'b1;
        w_state_nx = S_DONE;
      end
      S_DONE: if (bus.resp_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else if (w_load) begin
      r_op    <= bus.op;
      r_neg   <= w_neg_res;
      r_count <= '0;
      r_rem   <= '0;
      if (w_div) begin
        r_b   <= w_mag_b;
        r_acc <= {{W{1'b0}}, w_mag_a};
      end else begin
        r_b   <= w_mag_a;
        r_acc <= {{W{1'b0}}, w_mag_b};
      end
      if (w_short) r_result <= w_short_res;
    end else if (r_state == S_CALC) begin
      r_count <= r_count + 5'd1;
      if (r_op[2]) begin
        r_acc <= {r_acc[2*W-1:W], w_quo_nx};
        r_rem <= w_rem_nx;
      end else begin
        r_acc <= w_acc_mul;
      end
      if (w_fin) r_result <= w_final;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.resp_valid  = (r_state == S_DONE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.resp_result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq.
// Checks results and latency against an arithmetic reference model.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // called #1 after a rising edge with the unit idle
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold);
    int cyc;
    logic [31:0] exp;
    logic [31:0] held;
    exp = ref_model(op, a, b);
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk); #1;
    // garbage request while busy must be ignored
    bus.op = 3'($urandom);
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    cyc = 1;
    while (!bus.resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    chk($sformatf("latency op%0d", op), cyc, ref_lat(op, a, b));
    chk($sformatf("result op%0d %h,%h", op, a, b),
        bus.resp_result, exp);
    held = bus.resp_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", bus.resp_result, held);
      chk("hold_valid_rdy", {30'd0, bus.resp_valid, bus.req_ready},
          32'd2);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("post_hs", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
  endtask

  logic [2:0]  d_op [14] = '{5, 7, 4, 6, 4, 6, 4, 6, 1, 3, 0, 2, 5, 7};
  logic [31:0] d_a  [14] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             5, 5, 32'h8000_0000, 32'h8000_0000,
                             32'h8000_0000, 32'hFFFF_FFFF, 3,
                             32'hFFFF_FFFF, 7, 7};
  logic [31:0] d_b  [14] = '{7, 7, 2, 2, 0, 0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0};

  initial begin
    logic [31:0] ra, rb;
    logic        saw_valid;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", bus.resp_result, 32'd0);

    for (int i = 0; i < 14; i++)
      run_op(d_op[i], d_a[i], d_b[i], (i == 0) ? 10 : 0);

    // reset in cycle 10 of a DIVU discards the result
    bus.req_valid = 1'b1;
    bus.op = 3'd5;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    saw_valid = bus.resp_valid;
    repeat (30) begin
      @(posedge clk); #1;
      saw_valid |= bus.resp_valid;
    end
    chk("midrst_no_valid", {31'd0, saw_valid}, 32'd0);
    run_op(3'd5, 32'd9, 32'd3, 0);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
